ae_program_sequencer: RTL

Program sequencer for the autoencoder datapath. It owns the program counter that addresses the instruction memory and latches each fetched 16-bit instruction (opcode/field1/field2/field3, 4 bits each). It drives the per-phase strobes that let the sector selectors, ALU and memory write port act exactly once per instruction. It runs a program from address 0 on `start` until a HALT opcode or address wrap, then reports `done`.

---
 rtl/ae_program_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/ae_program_sequencer.sv
// Program sequencer: walks the PC through instruction memory and drives one phase strobe per instruction.
// Optional single-step mode (PAUSE state, `step` input) is enabled by defining AE_SEQ_STEP_EN.
module ae_program_sequencer #(
  parameter int         PC_WIDTH    = 4,
  parameter int         INSTR_WIDTH = 16,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   start,
`ifdef AE_SEQ_STEP_EN
  input  logic                   step,
`endif
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instr_q,
  output logic                   enable_sel_mem,
  output logic                   enable_ALU,
  output logic                   write_strobe,
  output logic                   busy,
  output logic                   done,
  output logic                   wrapped
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // FETCH  | pc stable, memory read in flight
  // DECODE | instr_in latched into instr_q; sector selectors load unless HALT
  // EXEC   | ALU enabled
  // WB     | memory write qualified; advance pc or finish on the last address
  // DONE   | program finished, waiting for a restart
  // PAUSE  | single-step hold between instructions (step mode only)
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
`ifdef AE_SEQ_STEP_EN
  localparam logic [2:0] S_PAUSE  = 3'd6;
`endif

  logic [2:0] state;
  logic       is_halt;
  logic       pc_last;

  assign is_halt = (instr_in[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
  assign pc_last = (pc == {PC_WIDTH{1'b1}});

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      instr_q <= '0;
      wrapped <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= '0;
            wrapped <= 1'b0;
          end
        end
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          instr_q <= instr_in;
          state   <= is_halt ? S_DONE : S_EXEC;
        end
        S_EXEC:   state <= S_WB;
        S_WB: begin
          if (pc_last) begin
            state   <= S_DONE;
            wrapped <= 1'b1;
          end else begin
            pc <= pc + 1'b1;
`ifdef AE_SEQ_STEP_EN
            state <= S_PAUSE;
`else
            state <= S_FETCH;
`endif
          end
        end
`ifdef AE_SEQ_STEP_EN
        S_PAUSE: if (step) state <= S_FETCH;
`endif
        default:  state <= S_IDLE;
      endcase
    end
  end

  // The load strobe must be suppressed for HALT, which is only known once the read data arrives in DECODE.
  assign enable_sel_mem = (state == S_DECODE) && !is_halt;
  assign enable_ALU     = (state == S_EXEC);
  assign write_strobe   = (state == S_WB);
  assign done           = (state == S_DONE);
`ifdef AE_SEQ_STEP_EN
  assign busy = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                (state == S_WB) || (state == S_PAUSE);
`else
  assign busy = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                (state == S_WB);
`endif

endmodule
